// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute,
// with combinational branch PC enable and ALU operation decode.
module controle_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_escreve,
  output logic       adr_src,
  output logic       mem_escreve,
  output logic       ir_escreve,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_controle,
  output logic       reg_escreve,
  output logic [3:0] estado
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pc_update, branch;
  logic       ir_raw, mem_raw, reg_raw;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src    = 1'b0;
    ir_raw     = 1'b0;
    mem_raw    = 1'b0;
    reg_raw    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_raw     = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
      end
      S_ALUWB:    reg_raw = 1'b1;
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtract only for R-type with funct7[5]; I-type funct7 bits are immediate.
  always_comb begin
    alu_controle = 3'b000;
    case (aluop)
      2'b01: alu_controle = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_controle = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_controle = 3'b101;
          3'b110:  alu_controle = 3'b011;
          3'b111:  alu_controle = 3'b010;
          default: alu_controle = 3'b000;
        endcase
      end
      default: alu_controle = 3'b000;
    endcase
  end

  // Reset holds state at FETCH, so write enables are masked while it is high.
  assign pc_escreve  = ~reset & (pc_update | (branch & zero));
  assign ir_escreve  = ~reset & ir_raw;
  assign mem_escreve = ~reset & mem_raw;
  assign reg_escreve = ~reset & reg_raw;
  assign estado      = state_q;

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  7  instr[6:0] from the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7_5  in  1  instr[30].
REQ-007 zero  in  1  ALU zero flag, same cycle.
REQ-008 pc_escreve  out  1  PC write enable.
REQ-009 adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 mem_escreve  out  1  data memory write enable.
REQ-011 ir_escreve  out  1  instruction register write enable (also latches oldPC).
REQ-012 result_src  out  2  select for the 4x1 result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result.
REQ-013 alu_src_a  out  2  select for the 4x1 source A mux: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-014 alu_src_b  out  2  select for the 4x1 source B mux: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-015 alu_controle  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 reg_escreve  out  1  register file write enable.
REQ-017 estado  out  4  current state encoding, for debug.

Function
REQ-018 The block SHALL be a Moore FSM with one 4-bit state register; only pc_escreve (via zero) and alu_controle (via funct3/funct7_5/opcode) SHALL depend combinationally on inputs.
REQ-019 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10; codes 11-15 SHALL transition to FETCH with all enables 0.
REQ-020 Every output not listed for a state SHALL be 0; internal aluop (2b) SHALL default to 00.
REQ-021 FETCH: adr_src=0, ir_escreve=1, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10, pc_update=1; next DECODE.
REQ-022 DECODE: alu_src_a=01, alu_src_b=01, aluop=00; next by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1101111 -> JAL, 1100011 -> BEQ, any other -> FETCH.
REQ-023 MEMADR: alu_src_a=10, alu_src_b=01, aluop=00; next MEMREAD if opcode=0000011, else MEMWRITE.
REQ-024 MEMREAD: result_src=00, adr_src=1; next MEMWB.  MEMWB: result_src=01, reg_escreve=1; next FETCH.
REQ-025 MEMWRITE: result_src=00, adr_src=1, mem_escreve=1; next FETCH.
REQ-026 EXECR: alu_src_a=10, alu_src_b=00, aluop=10; next ALUWB.  EXECI: alu_src_a=10, alu_src_b=01, aluop=10; next ALUWB.
REQ-027 ALUWB: result_src=00, reg_escreve=1; next FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_update=1; next ALUWB.
REQ-029 BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, branch=1; next FETCH.
REQ-030 pc_escreve SHALL equal pc_update OR (branch AND zero).
REQ-031 ALU decode: aluop 00 -> 000; 01 -> 001; 10 -> by funct3: 000 -> 001 if (opcode[5] AND funct7_5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other funct3 -> 000; aluop 11 -> 000.
REQ-032 Latency per instruction class SHALL be: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, unsupported opcode 2 cycles.

Reset
REQ-033 Asserting reset SHALL force the state to FETCH immediately, independent of clock.
REQ-034 While reset is high, pc_escreve, ir_escreve, mem_escreve and reg_escreve SHALL be 0; other outputs SHALL carry FETCH values; estado=0.
REQ-035 On the first rising edge after reset deasserts, the FETCH enables SHALL take effect; reset asserted mid-instruction SHALL abandon it with no further write enables.

Verification
REQ-036 Release reset, opcode=0000011 -> estado 0,1,2,3,4,0; reg_escreve=1 only in state 4 with result_src=01; 5 cycles.
REQ-037 opcode=0110011, funct3=000, funct7_5=1 -> EXECR shows alu_controle=001; same with funct3=110 -> 011; ALUWB reg_escreve=1.
REQ-038 opcode=1100011 in BEQ: zero=1 -> pc_escreve=1; zero=0 -> pc_escreve=0; next state FETCH in both.
REQ-039 opcode=0100011 -> states 0,1,2,5,0; mem_escreve=1 and adr_src=1 only in state 5; reg_escreve never 1.
REQ-040 opcode=1111111 -> DECODE returns to FETCH with no write enables; reset pulsed in MEMREAD -> estado=0 asynchronously, all enables 0 while high.
